// File: rtl/store_lane_writer_pkg.sv
// Shared store-size encodings and lane helpers for the store and load paths.
// Funct codes match the MEM-stage store opcodes.
package store_lane_writer_pkg;

   localparam logic [2:0] FNC_SB = 3'b000;
   localparam logic [2:0] FNC_SH = 3'b001;
   localparam logic [2:0] FNC_SW = 3'b010;

   typedef enum logic [1:0] {
      STORE_SIZE_B = 2'd0,
      STORE_SIZE_H = 2'd1,
      STORE_SIZE_W = 2'd2
   } store_size_e;

   function automatic logic is_legal(input logic [2:0] f);
      return (f == FNC_SB) || (f == FNC_SH) || (f == FNC_SW);
   endfunction

   function automatic store_size_e size_of(input logic [2:0] f);
      store_size_e s;
      unique case (1'b1)
         (f == FNC_SB): s = STORE_SIZE_B;
         (f == FNC_SH): s = STORE_SIZE_H;
         default:       s = STORE_SIZE_W;
      endcase
      return s;
   endfunction

   // 8-bit mask spans two words; the upper nibble is the second beat.
   function automatic logic [7:0] lane_mask(input store_size_e s,
                                            input logic [1:0] o);
      logic [7:0] b;
      case (s)
         STORE_SIZE_B: b = 8'h01;
         STORE_SIZE_H: b = 8'h03;
         default:      b = 8'h0f;
      endcase
      return b << o;
   endfunction

   function automatic logic [63:0] lane_data(input store_size_e s,
                                             input logic [1:0] o,
                                             input logic [31:0] d);
      logic [63:0] z;
      case (s)
         STORE_SIZE_B: z = {56'd0, d[7:0]};
         STORE_SIZE_H: z = {48'd0, d[15:0]};
         default:      z = {32'd0, d};
      endcase
      return z << {o, 3'b000};
   endfunction

endpackage

// File: rtl/store_lane_writer_if.sv
// Store request and memory write-port bundle for the store lane writer.
// slave is the writer's view, master the surrounding pipeline/memory.
interface store_lane_writer_if #(
   parameter int ADDR_W = 32
);
   logic              st_valid;
   logic              st_ready;
   logic [2:0]        st_funct;
   logic [ADDR_W-1:0] st_addr;
   logic [31:0]       st_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;

   modport master (
      output st_valid, st_funct, st_addr, st_data, mem_ready,
      input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
   );

   modport slave (
      input  st_valid, st_funct, st_addr, st_data, mem_ready,
      output st_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/store_fifo.sv
// Count-based store buffer; exposes head and the entry behind it so the
// writer can issue back-to-back beats.
module store_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 67
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [W-1:0]           nxt,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head  = mem[rp];
   assign nxt   = mem[rp + AW'(1)];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/store_lane_writer.sv
// Buffers MEM-stage stores and emits aligned 32-bit masked write beats,
// splitting word-crossing stores into two beats.
module store_lane_writer
   import store_lane_writer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   store_lane_writer_if.slave     bus,
   output logic                   empty,
   output logic                   err_illegal
);
   localparam int W  = ADDR_W + 35;
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BEAT0 = 2'd1;
   localparam logic [1:0] BEAT1 = 2'd2;

   logic [1:0]        state, state_d;
   logic [W-1:0]      head, nxt, ent;
   logic [CW-1:0]     count;
   logic              full, f_empty, push, pop, fin;
   logic              split_q, split_d;
   logic [2:0]        e_fn;
   logic [ADDR_W-1:0] e_addr, e_base;
   logic [31:0]       e_data;
   logic [7:0]        e_m8;
   logic [63:0]       e_d64;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        mask_q, mask_d;

   assign bus.st_ready = !full;
   assign push = bus.st_valid && !full && is_legal(bus.st_funct);

   // fin: the head's last beat is taken this cycle
   assign fin = bus.mem_ready &&
                ((state == BEAT1) || (state == BEAT0 && !split_q));
   assign pop = fin;
   assign ent = fin ? nxt : head;

   assign {e_fn, e_addr, e_data} = ent;
   assign e_base = {e_addr[ADDR_W-1:2], 2'b00};
   assign e_m8   = lane_mask(size_of(e_fn), e_addr[1:0]);
   assign e_d64  = lane_data(size_of(e_fn), e_addr[1:0], e_data);

   store_fifo #(
      .DEPTH(DEPTH),
      .W    (W)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push),
      .din  ({bus.st_funct, bus.st_addr, bus.st_data}),
      .pop  (pop),
      .head (head),
      .nxt  (nxt),
      .count(count),
      .full (full),
      .empty(f_empty)
   );

   always_comb begin
      state_d = state;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      split_d = split_q;
      unique case (1'b1)
         (state == IDLE && !f_empty),
         (fin && count > CW'(1)): begin
            state_d = BEAT0;
            addr_d  = e_base;
            wdata_d = e_d64[31:0];
            mask_d  = e_m8[3:0];
            split_d = |e_m8[7:4];
         end
         (fin && count <= CW'(1)): begin
            state_d = IDLE;
         end
         (state == BEAT0 && bus.mem_ready && split_q): begin
            state_d = BEAT1;
            addr_d  = e_base + ADDR_W'(4);
            wdata_d = e_d64[63:32];
            mask_d  = e_m8[7:4];
            split_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         split_q     <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         state       <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         split_q     <= split_d;
         err_illegal <= bus.st_valid && !full &&
                        !is_legal(bus.st_funct);
      end
   end

   assign bus.mem_valid = (state != IDLE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wmask = mask_q;
   assign empty = f_empty && (state == IDLE);

endmodule

// File: tb/tb_store_lane_writer.sv
// Directed bench for store_lane_writer with a beat-queue reference model.
module tb_store_lane_writer;
   import store_lane_writer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic empty;
   logic err_illegal;

   store_lane_writer_if #(.ADDR_W(32)) bus ();

   store_lane_writer #(
      .DEPTH (4),
      .ADDR_W(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .empty      (empty),
      .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      bit          last;
   } beat_t;

   beat_t       q[$];
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] log_a[32];
   logic [31:0] log_d[32];
   logic [3:0]  log_m[32];
   int          log_c[32];
   int          nlog = 0;
   int          cyc = 0;
   int          npulse = 0;
   bit          exp_err = 0;
   bit          hold = 0;
   logic [31:0] pa, pd;
   logic [3:0]  pm;
   int          nent;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Byte-lane arithmetic straight from the store rules
   function automatic void model(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] d, output beat_t b0,
                                 output beat_t b1, output bit two);
      int n;
      int o;
      logic [63:0] m;
      logic [63:0] dd;
      n  = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
      o  = int'(a % 4);
      m  = ((64'd1 << n) - 64'd1) << o;
      dd = (64'(d) & ((64'd1 << (8 * n)) - 64'd1)) << (8 * o);
      two = (m >> 4) != 64'd0;
      b0.a = a - (a % 4);
      b0.m = m[3:0];
      b0.d = dd[31:0];
      b0.last = !two;
      b1.a = b0.a + 32'd4;
      b1.m = m[7:4];
      b1.d = dd[63:32];
      b1.last = 1'b1;
   endfunction

   always @(negedge clk) begin
      beat_t e, b0, b1;
      bit two;
      cyc++;
      if (!rst_n) begin
         q.delete();
         hold = 0;
         exp_err = 0;
      end else begin
         nent = 0;
         foreach (q[i]) if (q[i].last) nent++;
         chk("empty", 32'(empty), 32'(q.size() == 0));
         chk("st_ready", 32'(bus.st_ready), 32'(nent < 4));
         chk("err_illegal", 32'(err_illegal), 32'(exp_err));
         if (err_illegal) npulse++;
         exp_err = 0;
         if (hold) begin
            chk("hold_valid", 32'(bus.mem_valid), 32'd1);
            chk("hold_addr", bus.mem_addr, pa);
            chk("hold_wdata", bus.mem_wdata, pd);
            chk("hold_wmask", 32'(bus.mem_wmask), 32'(pm));
         end
         if (bus.mem_valid)
            chk("wmask_nz", 32'(bus.mem_wmask != 4'd0), 32'd1);
         if (bus.mem_valid && bus.mem_ready) begin
            if (q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_beat: got addr %h want none",
                        bus.mem_addr);
            end else begin
               e = q.pop_front();
               chk("beat_addr", bus.mem_addr, e.a);
               chk("beat_wdata", bus.mem_wdata, e.d);
               chk("beat_wmask", 32'(bus.mem_wmask), 32'(e.m));
            end
            if (nlog < 32) begin
               log_a[nlog] = bus.mem_addr;
               log_d[nlog] = bus.mem_wdata;
               log_m[nlog] = bus.mem_wmask;
               log_c[nlog] = cyc;
               nlog++;
            end
         end
         hold = bus.mem_valid && !bus.mem_ready;
         pa = bus.mem_addr;
         pd = bus.mem_wdata;
         pm = bus.mem_wmask;
         if (bus.st_valid && bus.st_ready) begin
            if (bus.st_funct inside {3'b000, 3'b001, 3'b010}) begin
               model(bus.st_funct, bus.st_addr, bus.st_data, b0, b1, two);
               q.push_back(b0);
               if (two) q.push_back(b1);
            end else begin
               exp_err = 1;
            end
         end
      end
   end

   task automatic push(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
      int t = 0;
      bus.st_valid = 1'b1;
      bus.st_funct = f;
      bus.st_addr  = a;
      bus.st_data  = d;
      forever begin
         @(negedge clk);
         if (bus.st_ready) break;
         t++;
         if (t > 100) break;
      end
      if (t > 100) begin
         nvec++;
         nerr++;
         $display("FAIL push_timeout: got no ready want ready");
      end
      @(posedge clk);
      #1 bus.st_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((!empty || q.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         nvec++;
         nerr++;
         $display("FAIL drain_timeout: got busy want empty");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string nm, input int k, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d);
      chk({nm, "_addr"}, log_a[k], a);
      chk({nm, "_wmask"}, 32'(log_m[k]), 32'(m));
      chk({nm, "_wdata"}, log_d[k], d);
   endtask

   logic [15:0] pat = 16'b1011_0110_1101_0011;
   logic [2:0]  tf[6] = '{FNC_SB, FNC_SH, FNC_SW, FNC_SH, FNC_SB, FNC_SW};
   logic [31:0] ta[6] = '{32'h6001, 32'h6002, 32'h6003,
                          32'h6001, 32'h6000, 32'h6004};
   logic [31:0] td[6] = '{32'hA5, 32'hBEEF, 32'hCAFEF00D,
                          32'h7788, 32'h12345699, 32'h01020304};

   initial begin
      beat_t b0, b1;
      bit two;
      bus.st_valid  = 1'b0;
      bus.st_funct  = 3'b000;
      bus.st_addr   = '0;
      bus.st_data   = '0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_wmask", 32'(bus.mem_wmask), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      rst_n = 1'b1;
      #1 chk("rst_ready", 32'(bus.st_ready), 32'd1);

      model(FNC_SH, 32'h3003, 32'h1234, b0, b1, two);
      chk("pin_sh_split", 32'(two), 32'd1);
      chk("pin_sh_b0d", b0.d, 32'h34000000);
      chk("pin_sh_b1d", b1.d, 32'h00000012);
      model(FNC_SW, 32'hFFFFFFFE, 32'hA1B2C3D4, b0, b1, two);
      chk("pin_sw_b0m", 32'(b0.m), 32'hC);
      chk("pin_sw_b1a", b1.a, 32'h0);
      chk("pin_sw_b1d", b1.d, 32'h0000A1B2);

      @(posedge clk);
      #1 bus.mem_ready = 1'b1;
      nlog = 0;
      push(FNC_SW, 32'h1000, 32'hDEADBEEF);
      chk("t1_lat0", 32'(bus.mem_valid), 32'd0);
      @(posedge clk);
      #1 chk("t1_lat1", 32'(bus.mem_valid), 32'd1);
      drain();
      chk("t1_nbeats", 32'(nlog), 32'd1);
      chk_log("t1", 0, 32'h1000, 4'b1111, 32'hDEADBEEF);
      chk("t1_empty", 32'(empty), 32'd1);

      nlog = 0;
      push(FNC_SB, 32'h2003, 32'h000000AB);
      drain();
      chk("t2_nbeats", 32'(nlog), 32'd1);
      chk_log("t2", 0, 32'h2000, 4'b1000, 32'hAB000000);

      nlog = 0;
      push(FNC_SH, 32'h3003, 32'h00001234);
      drain();
      chk("t3_nbeats", 32'(nlog), 32'd2);
      chk_log("t3b0", 0, 32'h3000, 4'b1000, 32'h34000000);
      chk_log("t3b1", 1, 32'h3004, 4'b0001, 32'h00000012);
      chk("t3_b2b", 32'(log_c[1]), 32'(log_c[0] + 1));

      nlog = 0;
      push(FNC_SW, 32'hFFFFFFFE, 32'hA1B2C3D4);
      drain();
      chk("t4_nbeats", 32'(nlog), 32'd2);
      chk_log("t4b0", 0, 32'hFFFFFFFC, 4'b1100, 32'hC3D40000);
      chk_log("t4b1", 1, 32'h00000000, 4'b0011, 32'h0000A1B2);

      bus.mem_ready = 1'b0;
      nlog = 0;
      for (int k = 0; k < 4; k++)
         push(FNC_SW, 32'h4000 + 32'(4 * k), 32'h11110000 + 32'(k));
      chk("t5_full", 32'(bus.st_ready), 32'd0);
      bus.st_valid = 1'b1;
      bus.st_funct = FNC_SW;
      bus.st_addr  = 32'h4010;
      bus.st_data  = 32'h11110004;
      repeat (3) begin
         @(posedge clk);
         #1 chk("t5_stall_ready", 32'(bus.st_ready), 32'd0);
         chk("t5_stall_addr", bus.mem_addr, 32'h4000);
      end
      bus.mem_ready = 1'b1;
      begin
         int t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!bus.st_ready && t < 50);
         chk("t5_reopen", 32'(bus.st_ready), 32'd1);
      end
      @(posedge clk);
      #1 bus.st_valid = 1'b0;
      drain();
      chk("t5_nbeats", 32'(nlog), 32'd5);
      for (int k = 0; k < 5; k++)
         chk("t5_order", log_a[k], 32'h4000 + 32'(4 * k));
      for (int k = 0; k < 3; k++)
         chk("t5_b2b", 32'(log_c[k + 1]), 32'(log_c[k] + 1));

      nlog = 0;
      npulse = 0;
      push(3'b011, 32'h5000, 32'h55);
      repeat (3) @(posedge clk);
      drain();
      chk("t6_pulses", 32'(npulse), 32'd1);
      chk("t6_nbeats", 32'(nlog), 32'd0);

      nlog = 0;
      fork
         for (int k = 0; k < 6; k++) push(tf[k], ta[k], td[k]);
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 bus.mem_ready = pat[i % 16];
         end
      join
      bus.mem_ready = 1'b1;
      drain();
      chk("t7_nbeats", 32'(nlog), 32'd7);

      bus.mem_ready = 1'b0;
      push(FNC_SH, 32'h3003, 32'h00001234);
      @(posedge clk);
      #1 bus.mem_ready = 1'b1;
      @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      chk("t8_in_beat1", 32'(bus.mem_wmask), 32'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_rst_valid", 32'(bus.mem_valid), 32'd0);
      chk("t8_rst_empty", 32'(empty), 32'd1);
      chk("t8_rst_wmask", 32'(bus.mem_wmask), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      nlog = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("t8_no_replay", 32'(nlog), 32'd0);
      chk("t8_empty", 32'(empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
